// File: rtl/lc3_writeback_if.sv
// Writeback bus between execute (master) and the writeback stage (slave).
//   master drives : enable_writeback, W_Control, aluout, pcout, memout, dr, sr1, sr2
//   slave drives  : VSR1, VSR2 (register read data), psr (condition codes {N,Z,P})
interface lc3_writeback_if;
  logic        enable_writeback;
  logic [1:0]  W_Control;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [15:0] memout;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic [2:0]  psr;

  modport master (
    output enable_writeback, W_Control, aluout, pcout, memout, dr, sr1, sr2,
    input  VSR1, VSR2, psr
  );

  modport slave (
    input  enable_writeback, W_Control, aluout, pcout, memout, dr, sr1, sr2,
    output VSR1, VSR2, psr
  );
endinterface

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: owns the general register file and the NZP status register.
//   clock : rising-edge clock
//   reset : synchronous, active-high; clears all registers and psr
//   wb    : writeback bus (slave end) - commit strobe, result sources, register
//           indices in; asynchronous read data VSR1/VSR2 and psr out
module lc3_writeback #(
  parameter int unsigned NUM_REGS      = 8,
  parameter logic [15:0] REG_RESET_VAL = 16'h0000
) (
  input  logic            clock,
  input  logic            reset,
  lc3_writeback_if.slave  wb
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PSR_W  = 3;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_PC  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_RSV = 2'd3;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [PSR_W-1:0]  psr_q;
  logic [PSR_W-1:0]  psr_d;
  logic [DATA_W-1:0] wb_data;
  logic              commit;

  // Result select; the reserved code suppresses the commit entirely
  always_comb begin
    wb_data = wb.aluout;
    case (wb.W_Control)
      SEL_ALU: wb_data = wb.aluout;
      SEL_PC:  wb_data = wb.pcout;
      SEL_MEM: wb_data = wb.memout;
      default: wb_data = wb.aluout;
    endcase
    commit = wb.enable_writeback && (wb.W_Control != SEL_RSV);
  end

  // Next-state for register file and condition codes
  always_comb begin
    regs_d = regs_q;
    psr_d  = psr_q;
    if (commit) begin
      regs_d[wb.dr] = wb_data;
      if (wb_data[DATA_W-1])
        psr_d = 3'b100;
      else if (wb_data == '0)
        psr_d = 3'b010;
      else
        psr_d = 3'b001;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= REG_RESET_VAL;
      psr_q <= '0;
    end else begin
      regs_q <= regs_d;
      psr_q  <= psr_d;
    end
  end

  // Reads come from the stored array only: no bypass of an in-flight commit
  assign wb.VSR1 = regs_q[wb.sr1];
  assign wb.VSR2 = regs_q[wb.sr2];
  assign wb.psr  = psr_q;

endmodule

// File: doc/lc3_writeback.md
Name: lc3_writeback

Overview:
- Writeback stage of the LC3 pipeline. It owns the 8-entry x 16-bit general register file and the NZP processor status register.
- When enable_writeback is asserted, it writes the selected result (ALU, PC or memory) to register dr and updates psr.
- It continuously drives register read data VSR1/VSR2 back to execute.
- It is the responder end of the writeback_out bus: it drives VSR1, VSR2 and psr, and consumes enable_writeback.

Parameters:
- NUM_REGS, 8, number of general registers; sr1/sr2/dr width fixed at 3 bits.
- REG_RESET_VAL, 16'h0000, value loaded into every register on reset.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable_writeback  input  1  commit strobe for this cycle's result
- W_Control  input  2  result select: 0=aluout, 1=pcout, 2=memout, 3=reserved
- aluout  input  16  ALU result from execute
- pcout  input  16  PC-relative result from execute
- memout  input  16  load data from memory access
- dr  input  3  destination register index
- sr1  input  3  source register 1 index
- sr2  input  3  source register 2 index
- VSR1  output  16  contents of register sr1
- VSR2  output  16  contents of register sr2
- psr  output  3  condition codes {N,Z,P}

Behaviour:
- Interface: one clock (clock). Reset (reset) is synchronous and active-high. All state changes occur on the rising edge of clock.
- Reset:
  - All registers R0..R7 are set to REG_RESET_VAL.
  - psr is set to 3'b000.
  - Reset has priority over enable_writeback in the same cycle; no write occurs.
  - Reset asserted mid-sequence discards the in-flight commit.
- Result mux (combinational):
  - wb_data = aluout when W_Control=0, pcout when 1, memout when 2.
  - W_Control=3 is reserved: no register write and no psr update, even with enable_writeback=1.
- Commit: on a rising edge with reset=0, enable_writeback=1 and W_Control!=3:
  - R[dr] <= wb_data.
  - psr <= 3'b100 if wb_data[15]=1; 3'b010 if wb_data==0; otherwise 3'b001.
  - Exactly one psr bit is set after any commit.
- enable_writeback=0: register file and psr hold their values; inputs are don't-care.
- Reads:
  - VSR1=R[sr1] and VSR2=R[sr2] are combinational (asynchronous) reads of the stored array.
  - There is no write bypass. When sr1 or sr2 equals dr in a commit cycle, VSRx shows the old value in that cycle and the new value from the following cycle.
  - sr1==sr2 is legal; both outputs show the same register.
- Latency: commit is visible on psr and VSRx one cycle after the commit edge. Back-to-back commits every cycle are supported.
- R0 is an ordinary writable register; there is no hardwired zero.
- psr reflects only the most recent committed value. It is not updated by reads.
- No X propagation: after reset, all outputs are known values for any sr1/sr2.

Test Plan:
- Reset: assert reset 2 cycles, then sr1=0..7 sweep -> VSR1=16'h0000 for every index; psr=3'b000.
- ALU commit: W_Control=0, aluout=16'h8001, dr=3, enable_writeback=1 for one cycle; next cycle sr1=3 -> VSR1=16'h8001, psr=3'b100.
- Select paths:
  - W_Control=1, pcout=16'h0000, dr=5 -> R5=0, psr=3'b010.
  - W_Control=2, memout=16'h1234, dr=6 -> R6=16'h1234, psr=3'b001.
- Hazards:
  - Commit aluout=16'h00AA to dr=2 with sr1=sr2=2 in the same cycle -> VSR1=VSR2=old R2 that cycle, 16'h00AA the next.
  - W_Control=3 with enable_writeback=1, dr=2 -> R2 and psr unchanged.
- Gating: enable_writeback=0 with aluout=16'hFFFF, dr=1 for 10 cycles -> R1 and psr unchanged.
- Reset priority: reset=1 and enable_writeback=1 (aluout=16'h7FFF, dr=4) in the same cycle -> R4=16'h0000, psr=3'b000.
- Back-to-back: writes to dr=0..7 on consecutive cycles with values 16'h0101*(i+1) -> each readback matches; psr=3'b001 after the final write.
